// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side sequencer for a UART RX path. It synchronises the raw serial
// line and qualifies the start bit at mid-bit. It then samples each data bit at
// mid-bit and hands it to an external shift register as a one-cycle strobe.
// Finally it checks the stop bit and reports frame completion or a framing
// error.
//
// Ports:
//   CLK       - system clock, all logic on the rising edge
//   RST       - asynchronous, active-high reset
//   RX        - raw serial line, idle high, asynchronous to CLK
//   SHIFT_EN  - one-cycle strobe per data bit (shift register RXEN)
//   SHIFT_BIT - sampled data bit, valid while SHIFT_EN=1 (shift register DATA_IN)
//   RX_DONE   - one-cycle pulse: stop bit was 1, shift register holds the byte
//   FRAME_ERR - one-cycle pulse: stop bit was sampled 0
//   BUSY      - high whenever the sequencer is not in IDLE
//
// Data is passed through in line order (LSB first). The shift register inserts
// at bit 0, so the consumer sees the character bit-reversed.
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic RX,
    output logic SHIFT_EN,
    output logic SHIFT_BIT,
    output logic RX_DONE,
    output logic FRAME_ERR,
    output logic BUSY
);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx_ctrl: CLKS_PER_BIT must be >= 4");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("uart_rx_ctrl: SYNC_STAGES must be >= 2");
    end

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

    // ------------------------------------------------------------------
    // Input synchroniser. It resets to the idle (high) line level so that
    // leaving reset never looks like a start edge.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // NOTE: every register in this block has a reset value, which fixes the
    // outputs the moment RST rises, even mid-frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= '1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so each
            // stage samples the previous stage's old value.
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [2:0]        state_q,   state_d;
    logic [BAUD_W-1:0] baud_q,    baud_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              shift_en_d, shift_bit_d, rx_done_d, frame_err_d;

    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_en_d  = 1'b0;
        shift_bit_d = SHIFT_BIT;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) state_d = ST_START;
            end
            ST_START: begin
                // Re-check the line half a bit after the falling edge. A high
                // line here means the edge was a glitch.
                if (baud_q == BAUD_HALF) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                // START left at mid start bit, so each full bit period from
                // here lands in the middle of the next data bit.
                if (baud_q == BAUD_LAST) begin
                    shift_en_d  = 1'b1;
                    shift_bit_d = rx_s;
                    bit_cnt_d   = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    if (rx_s) begin
                        rx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line (break) must return high before a new frame
                // can start.
                if (rx_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The baud counter restarts on every state change so each state
        // measures time from its own entry.
        if (state_d != state_q) begin
            baud_d = '0;
        end else if (baud_q == BAUD_LAST) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            SHIFT_EN  <= 1'b0;
            SHIFT_BIT <= 1'b0;
            RX_DONE   <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            SHIFT_EN  <= shift_en_d;
            SHIFT_BIT <= shift_bit_d;
            RX_DONE   <= rx_done_d;
            FRAME_ERR <= frame_err_d;
        end
    end

    assign BUSY = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART RX path. It synchronises the serial line, detects and qualifies the start bit, and samples each data bit at mid-bit. For each data bit it issues one single-cycle shift strobe and data bit to the RX shift register (its RXEN / DATA_IN inputs), then checks the stop bit. It reports frame completion or a framing error to the downstream byte consumer.

Parameters:
CLKS_PER_BIT, 16, CLK cycles per serial bit; legal range >= 4; elaboration error otherwise
DATA_BITS, 8, data bits per frame; must equal the shift register SIZE
SYNC_STAGES, 2, flops in the RX input synchroniser; legal range >= 2

Ports:
CLK  input  1  single system clock, all logic on rising edge
RST  input  1  asynchronous, active-high reset
RX  input  1  raw serial line, idle high, asynchronous to CLK
SHIFT_EN  output  1  one-cycle strobe per data bit; drives shift register RXEN
SHIFT_BIT  output  1  sampled data bit; drives shift register DATA_IN; valid when SHIFT_EN=1
RX_DONE  output  1  one-cycle pulse: frame complete, stop bit = 1, shift register holds the byte
FRAME_ERR  output  1  one-cycle pulse: stop bit sampled 0
BUSY  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert by design): state=IDLE, synchroniser flops=1, bit counter=0, baud counter=0. SHIFT_EN=0, SHIFT_BIT=0, RX_DONE=0, FRAME_ERR=0, BUSY=0.
- rx_s = output of the SYNC_STAGES-deep synchroniser. All decisions use rx_s only.
- Baud counter: width $clog2(CLKS_PER_BIT). It clears on every state change. Otherwise it increments, wrapping to 0 after CLKS_PER_BIT-1.
- HALF = (CLKS_PER_BIT-1)/2 (integer division).
- States:
  - IDLE: if rx_s=0, go to START with baud counter=0.
  - START: when baud counter = HALF:
    - rx_s=0: go to DATA, clear baud counter and bit counter.
    - rx_s=1: glitch; go to IDLE with no outputs.
  - DATA: when baud counter = CLKS_PER_BIT-1:
    - Register SHIFT_EN=1 and SHIFT_BIT=rx_s for exactly the next cycle; increment bit counter.
    - After the DATA_BITS-th strobe, go to STOP.
    - Strobes are exactly CLKS_PER_BIT cycles apart. Each sample is taken at mid-bit.
  - STOP: when baud counter = CLKS_PER_BIT-1:
    - rx_s=1: pulse RX_DONE for 1 cycle, go to IDLE.
    - rx_s=0: pulse FRAME_ERR for 1 cycle, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition (line held low) from retriggering frames.
- Output timing:
  - RX_DONE asserts no earlier than 1 cycle after the last SHIFT_EN.
  - SHIFT_EN and RX_DONE are never high in the same cycle.
  - RX_DONE and FRAME_ERR are mutually exclusive.
- Bit order: the line is LSB first and the shift register inserts at [0]. After a frame, DATA_OUT[DATA_BITS-1] holds character bit 0. Bit reversal is the consumer's responsibility; this block does not reorder.
- Back-to-back frames: from IDLE, a start edge on the cycle after RX_DONE is accepted. No dead cycles beyond the state transition.
- Reset mid-frame: returns to IDLE immediately and no pulse is emitted. Shift register contents are not cleared; they are don't-care until the next RX_DONE.
- Counters never exceed their terminal values. The bit counter width is $clog2(DATA_BITS+1).

Test Plan:
1. CLKS_PER_BIT=16: send 0x01 (start, bits 1,0,0,0,0,0,0,0, stop). Required: 8 SHIFT_EN pulses spaced 16 cycles apart with SHIFT_BIT 1,0,0,0,0,0,0,0; then one RX_DONE; shift register DATA_OUT=0x80; FRAME_ERR never asserts.
2. Glitch: RX low for 4 cycles, then high. Required: BUSY high for about 7 cycles (through START), then IDLE; no SHIFT_EN, RX_DONE or FRAME_ERR.
3. Framing error: send 0x5A with stop bit 0, then hold RX low for 40 cycles, then release. Required: 8 strobes, one FRAME_ERR, no RX_DONE, BUSY held high until 2 cycles after RX rises; no new START entered while low.
4. Back-to-back: 0xA5 then 0x3C with no idle bits between frames. Required: two RX_DONE pulses exactly 10×16 cycles apart; DATA_OUT=0xA5, then 0x3C (bit-reversed).
5. Reset mid-frame: assert RST during the 4th data bit of 0xFF. Required: outputs go to reset values immediately; no RX_DONE; next clean 0x81 frame gives RX_DONE and DATA_OUT=0x81.
6. CLKS_PER_BIT=5 (odd, minimal): send 0x96. Required: HALF=2; strobes 5 cycles apart with correct bits; one RX_DONE.
